// File: rtl/packet_loader_pkg.sv
// packet_loader_pkg
// Shared widths, boolean constants, FSM state encodings and the byte-lane
// insertion helper used by the packet loader and its byte packer.
package packet_loader_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    LD_RECV  = 2'd0,
    LD_WRITE = 2'd1,
    LD_HDR   = 2'd2,
    LD_RUN   = 2'd3
  } ld_state_t;

  // Place one byte into the selected little-endian lane of a 32-bit word.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      2'd3:    w[31:24] = data;
      default: w = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/packet_loader_if.sv
// packet_loader_if
// Bundles the byte-stream ingress, the packet SRAM write port and the
// executor start/done handshake of the packet loader.
//   master : the loader side (drives rx_ready, memory port, start, status)
//   slave  : the environment side (drives rx stream and exec_done)
interface packet_loader_if;
  import packet_loader_pkg::*;

  logic                rx_valid_i;
  logic [7:0]          rx_data_i;
  logic                rx_last_i;
  logic                rx_ready_o;
  logic                mem_ce_o;
  logic                mem_we_o;
  logic [ADDR_BUS-1:0] mem_addr_o;
  logic [3:0]          mem_width_o;
  logic [DATA_BUS-1:0] mem_data_o;
  logic                start_o;
  logic [ADDR_BUS-1:0] start_addr_o;
  logic [15:0]         pkt_len_o;
  logic                drop_o;
  logic                exec_done_i;

  modport master (
    input  rx_valid_i, rx_data_i, rx_last_i, exec_done_i,
    output rx_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, start_o, start_addr_o, pkt_len_o, drop_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, rx_last_i, exec_done_i,
    input  rx_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, start_o, start_addr_o, pkt_len_o, drop_o
  );

endinterface

// File: rtl/packet_loader_byte_packer.sv
// packet_loader_byte_packer
// Accumulates incoming bytes into a 32-bit little-endian word buffer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : store data into lane this cycle
//   clear      : zero the buffer (word has been written out)
//   lane, data : target lane and byte
//   word       : current buffer contents
//   word_next  : buffer contents after this cycle's update
//   full       : lane 3 is being filled this cycle
module packet_loader_byte_packer
  import packet_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [1:0]  lane,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        full
);

  // Next buffer value; load wins over clear because they are never both set.
  always_comb begin
    word_next = word;
    if (load) begin
      word_next = lane_insert(word, lane, data);
    end else if (clear) begin
      word_next = 32'd0;
    end else begin
      word_next = word;
    end
  end

  // Flag that the current byte completes a word.
  always_comb begin
    full = FALSE;
    if (load && (lane == 2'd3)) begin
      full = TRUE;
    end else begin
      full = FALSE;
    end
  end

  // Word buffer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= 32'd0;
    end else begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/packet_loader.sv
// packet_loader
// Packet ingress writer: packs an incoming byte stream little-endian into
// 32-bit words, writes them to packet SRAM from BASE_ADDR upward, then
// raises start until the executor reports done.
// Parameters:
//   BASE_ADDR : byte address of the first packet word (word aligned)
//   MAX_BYTES : packet buffer capacity in bytes (multiple of 4)
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : packet_loader_if.master (rx stream, memory port, start/done)
// Optional feature macro: LOADER_LEN_HDR_EN -- after the last data word,
//   write {16'd0, pkt_len} at BASE_ADDR-4 and delay start by one cycle.
// All interface outputs are registered; each is computed from the
// next-state values so that it is valid during the corresponding state.
module packet_loader
  import packet_loader_pkg::*;
#(
  parameter int BASE_ADDR = 64,
  parameter int MAX_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  packet_loader_if.master  bus
);

`ifdef LOADER_LEN_HDR_EN
  localparam ld_state_t AFTER_DATA = LD_HDR;
`else
  localparam ld_state_t AFTER_DATA = LD_RUN;
`endif

  localparam logic [15:0]         MAX_CNT  = 16'(MAX_BYTES);
  localparam logic [ADDR_BUS-1:0] BASE     = ADDR_BUS'(BASE_ADDR);
  localparam logic [ADDR_BUS-1:0] HDR_ADDR = ADDR_BUS'(BASE_ADDR - 4);

  ld_state_t   state;
  ld_state_t   state_next;

  logic [15:0] byte_cnt;
  logic [15:0] byte_cnt_next;
  logic [15:0] word_idx;
  logic [15:0] word_idx_next;
  logic        drop;
  logic        drop_next;
  logic        word_last;
  logic        word_last_next;

  logic        accept;
  logic        pk_load;
  logic        pk_clear;
  logic [31:0] pk_word;
  logic [31:0] pk_word_next;
  logic        pk_full;

  logic                mem_ce_next;
  logic [ADDR_BUS-1:0] mem_addr_next;
  logic [DATA_BUS-1:0] mem_data_next;

  // rx_ready_o is the registered image of state == RECV.
  assign accept = bus.rx_valid_i && bus.rx_ready_o;

  packet_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .load      (pk_load),
    .clear     (pk_clear),
    .lane      (byte_cnt[1:0]),
    .data      (bus.rx_data_i),
    .word      (pk_word),
    .word_next (pk_word_next),
    .full      (pk_full)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_next     = state;
    byte_cnt_next  = byte_cnt;
    word_idx_next  = word_idx;
    drop_next      = drop;
    word_last_next = word_last;
    pk_load        = FALSE;
    pk_clear       = FALSE;
    case (state)
      LD_RECV: begin
        if (accept) begin
          if (byte_cnt == MAX_CNT) begin
            // Buffer full: swallow the byte, counter saturates.
            drop_next = TRUE;
            if (bus.rx_last_i) begin
              state_next = AFTER_DATA;
            end else begin
              state_next = LD_RECV;
            end
          end else begin
            pk_load        = TRUE;
            byte_cnt_next  = byte_cnt + 16'd1;
            word_last_next = bus.rx_last_i;
            if (pk_full || bus.rx_last_i) begin
              state_next = LD_WRITE;
            end else begin
              state_next = LD_RECV;
            end
          end
        end else begin
          state_next = LD_RECV;
        end
      end
      LD_WRITE: begin
        pk_clear       = TRUE;
        word_idx_next  = word_idx + 16'd1;
        word_last_next = FALSE;
        if (word_last) begin
          state_next = AFTER_DATA;
        end else begin
          state_next = LD_RECV;
        end
      end
      LD_HDR: begin
        state_next = LD_RUN;
      end
      LD_RUN: begin
        if (bus.exec_done_i) begin
          byte_cnt_next = 16'd0;
          word_idx_next = 16'd0;
          drop_next     = FALSE;
          state_next    = LD_RECV;
        end else begin
          state_next = LD_RUN;
        end
      end
      default: begin
        state_next = LD_RECV;
      end
    endcase
  end

  // Memory port values for the state being entered.
  always_comb begin
    mem_ce_next   = FALSE;
    mem_addr_next = '0;
    mem_data_next = '0;
    case (state_next)
      LD_WRITE: begin
        mem_ce_next   = TRUE;
        mem_addr_next = BASE + ADDR_BUS'({word_idx_next, 2'b00});
        mem_data_next = pk_word_next;
      end
      LD_HDR: begin
        mem_ce_next   = TRUE;
        mem_addr_next = HDR_ADDR;
        mem_data_next = {16'd0, byte_cnt_next};
      end
      default: begin
        mem_ce_next   = FALSE;
        mem_addr_next = '0;
        mem_data_next = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_RECV;
    end else begin
      state <= state_next;
    end
  end

  // Datapath counters and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 16'd0;
      word_idx  <= 16'd0;
      drop      <= FALSE;
      word_last <= FALSE;
    end else begin
      byte_cnt  <= byte_cnt_next;
      word_idx  <= word_idx_next;
      drop      <= drop_next;
      word_last <= word_last_next;
    end
  end

  // Registered interface outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_ready_o  <= FALSE;
      bus.mem_ce_o    <= FALSE;
      bus.mem_we_o    <= FALSE;
      bus.mem_addr_o  <= '0;
      bus.mem_width_o <= 4'd0;
      bus.mem_data_o  <= '0;
      bus.start_o     <= FALSE;
      bus.pkt_len_o   <= 16'd0;
      bus.drop_o      <= FALSE;
    end else begin
      bus.rx_ready_o  <= (state_next == LD_RECV);
      bus.mem_ce_o    <= mem_ce_next;
      bus.mem_we_o    <= mem_ce_next;
      bus.mem_addr_o  <= mem_addr_next;
      bus.mem_width_o <= mem_ce_next ? 4'd4 : 4'd0;
      bus.mem_data_o  <= mem_data_next;
      bus.start_o     <= (state_next == LD_RUN);
      bus.pkt_len_o   <= byte_cnt_next;
      bus.drop_o      <= drop_next;
    end
  end

  assign bus.start_addr_o = BASE;

endmodule

// File: tb/tb_packet_loader.sv
module tb_packet_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  packet_loader_if if0 ();
  packet_loader_if if1 ();

  packet_loader #(.BASE_ADDR(64), .MAX_BYTES(1024)) u_dut (
    .clk (clk), .rst (rst), .bus (if0)
  );

  packet_loader #(.BASE_ADDR(64), .MAX_BYTES(8)) u_small (
    .clk (clk), .rst (rst), .bus (if1)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] wa0[$];
  logic [31:0] wd0[$];
  logic [31:0] wa1[$];
  logic [31:0] wd1[$];
  int          bad_ctl = 0;

  // Write log: memory port is registered, sample on the falling edge.
  always @(negedge clk) begin
    if (if0.mem_ce_o === 1'b1) begin
      wa0.push_back(if0.mem_addr_o);
      wd0.push_back(if0.mem_data_o);
      if (if0.mem_we_o !== 1'b1 || if0.mem_width_o !== 4'd4) bad_ctl++;
    end
    if (if1.mem_ce_o === 1'b1) begin
      wa1.push_back(if1.mem_addr_o);
      wd1.push_back(if1.mem_data_o);
      if (if1.mem_we_o !== 1'b1 || if1.mem_width_o !== 4'd4) bad_ctl++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? if0.rx_ready_o : if1.rx_ready_o;
  endfunction

  function automatic logic stv(input int w);
    return (w == 0) ? if0.start_o : if1.start_o;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_byte(input int w, input logic [7:0] d, input logic last);
    int n;
    n = 0;
    while (rdy(w) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(rdy(w)), 32'd1);
    if (w == 0) begin
      if0.rx_valid_i = 1'b1; if0.rx_data_i = d; if0.rx_last_i = last;
    end else begin
      if1.rx_valid_i = 1'b1; if1.rx_data_i = d; if1.rx_last_i = last;
    end
    @(negedge clk);
    if0.rx_valid_i = 1'b0; if0.rx_last_i = 1'b0;
    if1.rx_valid_i = 1'b0; if1.rx_last_i = 1'b0;
  endtask

  task automatic wait_start(input int w);
    int n;
    n = 0;
    while (stv(w) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_wait", 32'(stv(w)), 32'd1);
  endtask

  // Hold start for 10 cycles, then pulse done and expect a return to RECV.
  task automatic release_pkt(input int w);
    repeat (10) @(negedge clk);
    chk("start_held", 32'(stv(w)), 32'd1);
    if (w == 0) if0.exec_done_i = 1'b1; else if1.exec_done_i = 1'b1;
    @(negedge clk);
    if0.exec_done_i = 1'b0;
    if1.exec_done_i = 1'b0;
    chk("start_fall", 32'(stv(w)), 32'd0);
    chk("ready_after_done", 32'(rdy(w)), 32'd1);
  endtask

  int base;
  logic [7:0] b5[5];

  initial begin
    if0.rx_valid_i = 1'b0; if0.rx_data_i = 8'd0; if0.rx_last_i = 1'b0; if0.exec_done_i = 1'b0;
    if1.rx_valid_i = 1'b0; if1.rx_data_i = 8'd0; if1.rx_last_i = 1'b0; if1.exec_done_i = 1'b0;
    b5[0] = 8'hAA; b5[1] = 8'hBB; b5[2] = 8'hCC; b5[3] = 8'hDD; b5[4] = 8'hEE;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(if0.rx_ready_o), 32'd0);
    chk("rst_ce", 32'(if0.mem_ce_o), 32'd0);
    chk("rst_start", 32'(if0.start_o), 32'd0);
    chk("rst_start_addr", if0.start_addr_o, 32'd64);
    chk("rst_len", 32'(if0.pkt_len_o), 32'd0);
    chk("rst_drop", 32'(if0.drop_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(if0.rx_ready_o), 32'd1);

    // 8-byte packet 01..08
    base = wa0.size();
    for (int i = 1; i <= 8; i++) send_byte(0, 8'(i), (i == 8));
    chk("p1_last_write_ce", 32'(if0.mem_ce_o), 32'd1);
    chk("p1_last_write_addr", if0.mem_addr_o, 32'd68);
    chk("p1_start_not_yet", 32'(if0.start_o), 32'd0);
    @(negedge clk);
`ifdef LOADER_LEN_HDR_EN
    chk("p1_hdr_ce", 32'(if0.mem_ce_o), 32'd1);
    chk("p1_hdr_start_low", 32'(if0.start_o), 32'd0);
    @(negedge clk);
`endif
    chk("p1_start_rise", 32'(if0.start_o), 32'd1);
    chk("p1_ready_low", 32'(if0.rx_ready_o), 32'd0);
`ifdef LOADER_LEN_HDR_EN
    chk("p1_nwrites", 32'(wa0.size() - base), 32'd3);
    chk("p1_a2", wa0[base+2], 32'd60);
    chk("p1_d2", wd0[base+2], 32'd8);
`else
    chk("p1_nwrites", 32'(wa0.size() - base), 32'd2);
`endif
    chk("p1_a0", wa0[base], 32'd64);
    chk("p1_d0", wd0[base], 32'h04030201);
    chk("p1_a1", wa0[base+1], 32'd68);
    chk("p1_d1", wd0[base+1], 32'h08070605);
    chk("p1_len", 32'(if0.pkt_len_o), 32'd8);
    chk("p1_drop", 32'(if0.drop_o), 32'd0);
    chk("p1_start_addr", if0.start_addr_o, 32'd64);
    release_pkt(0);
    chk("p1_len_cleared", 32'(if0.pkt_len_o), 32'd0);

    // 5-byte packet AA..EE, with a stray done pulse while receiving
    base = wa0.size();
    send_byte(0, b5[0], 1'b0);
    if0.exec_done_i = 1'b1;
    @(negedge clk);
    if0.exec_done_i = 1'b0;
    chk("stray_done_ready", 32'(if0.rx_ready_o), 32'd1);
    for (int i = 1; i < 5; i++) send_byte(0, b5[i], (i == 4));
    wait_start(0);
    chk("p2_a0", wa0[base], 32'd64);
    chk("p2_d0", wd0[base], 32'hDDCCBBAA);
    chk("p2_a1", wa0[base+1], 32'd68);
    chk("p2_d1", wd0[base+1], 32'h000000EE);
    chk("p2_len", 32'(if0.pkt_len_o), 32'd5);
    release_pkt(0);

    // 4-byte packet lands at 64 again
    base = wa0.size();
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h44, 1'b1);
    wait_start(0);
    chk("p3_a0", wa0[base], 32'd64);
    chk("p3_d0", wd0[base], 32'h44332211);
    chk("p3_len", 32'(if0.pkt_len_o), 32'd4);
    release_pkt(0);

    // Reset after 3 bytes: nothing written, then a clean packet
    base = wa0.size();
    send_byte(0, 8'hA1, 1'b0);
    send_byte(0, 8'hA2, 1'b0);
    send_byte(0, 8'hA3, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_nwrites", 32'(wa0.size() - base), 32'd0);
    chk("mid_rst_start", 32'(if0.start_o), 32'd0);
    chk("mid_rst_len", 32'(if0.pkt_len_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h66, 1'b0);
    send_byte(0, 8'h77, 1'b0);
    send_byte(0, 8'h88, 1'b1);
    wait_start(0);
    chk("p4_a0", wa0[base], 32'd64);
    chk("p4_d0", wd0[base], 32'h88776655);
    chk("p4_len", 32'(if0.pkt_len_o), 32'd4);
    release_pkt(0);

    // Overflow: MAX_BYTES=8, 12-byte packet
    base = wa1.size();
    for (int i = 0; i < 12; i++) send_byte(1, 8'(8'h10 + i), (i == 11));
    wait_start(1);
`ifdef LOADER_LEN_HDR_EN
    chk("ovf_nwrites", 32'(wa1.size() - base), 32'd3);
    chk("ovf_a2", wa1[base+2], 32'd60);
    chk("ovf_d2", wd1[base+2], 32'd8);
`else
    chk("ovf_nwrites", 32'(wa1.size() - base), 32'd2);
`endif
    chk("ovf_a0", wa1[base], 32'd64);
    chk("ovf_d0", wd1[base], 32'h13121110);
    chk("ovf_a1", wa1[base+1], 32'd68);
    chk("ovf_d1", wd1[base+1], 32'h17161514);
    chk("ovf_drop", 32'(if1.drop_o), 32'd1);
    chk("ovf_len", 32'(if1.pkt_len_o), 32'd8);
    release_pkt(1);
    chk("ovf_drop_cleared", 32'(if1.drop_o), 32'd0);
    chk("ovf_len_cleared", 32'(if1.pkt_len_o), 32'd0);

    chk("write_ctl_we_width", 32'(bad_ctl), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/packet_loader.md
# packet_loader

Packet ingress writer for the reconfigurable switch datapath. It accepts an incoming packet as a byte stream and packs it little-endian into 32-bit words. Each word is written into packet SRAM at `BASE_ADDR` upward through the same `ce/we/addr/width/data` memory port the `executor` uses. It then raises `start_o` with `start_addr_o = BASE_ADDR`, holds it until the executor reports `exec_done_i`, and only then accepts the next packet.

## Interface
Parameters:
- `BASE_ADDR`, default 64: byte address of the first packet word. Word-aligned.
- `MAX_BYTES`, default 1024: packet buffer capacity in bytes. Multiple of 4.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid_i`  in  1  byte valid.
- `rx_data_i`  in  8  packet byte.
- `rx_last_i`  in  1  this byte is the final byte of the packet; qualified by `rx_valid_i`.
- `rx_ready_o`  out  1  loader accepts a byte this cycle.
- `mem_ce_o`  out  1  memory request.
- `mem_we_o`  out  1  write enable; always 1 whenever `mem_ce_o` is 1.
- `mem_addr_o`  out  `ADDR_BUS`  byte address.
- `mem_width_o`  out  4  access width in bytes; always 4'd4 when `mem_ce_o` is 1.
- `mem_data_o`  out  `DATA_BUS`  write data.
- `start_o`  out  1  packet ready; level signal, held until done.
- `start_addr_o`  out  `ADDR_BUS`  constant `BASE_ADDR`.
- `pkt_len_o`  out  16  stored byte count of the current packet.
- `drop_o`  out  1  sticky; set when the current packet exceeded `MAX_BYTES`.
- `exec_done_i`  in  1  executor finished the packet.

## Operation
- States:
  - RECV: `rx_ready_o`=1.
  - WRITE: one cycle, memory write.
  - HDR: only with `LOADER_LEN_HDR_EN`.
  - RUN: `start_o`=1.
- RECV:
  - Each accepted byte goes into lane `byte_cnt[1:0]` of `word_buf` (lane 0 = bits 7:0).
  - `byte_cnt` increments by 1.
  - When lane 3 fills, or on `rx_last_i`, go to WRITE.
- WRITE:
  - Drive `mem_ce_o`=`mem_we_o`=1, `mem_addr_o` = `BASE_ADDR + 4*word_idx`, `mem_data_o` = `word_buf`.
  - Unfilled tail lanes are zero.
  - Then clear `word_buf` and increment `word_idx`.
  - Next state: RECV if the word was not last. If it was last, HDR when the macro is defined, otherwise RUN.
- RUN: hold `start_o`=1. On `exec_done_i`=1, clear `byte_cnt`, `word_idx` and `drop_o`, then return to RECV.
- Overflow:
  - Bytes arriving once `byte_cnt == MAX_BYTES` are still accepted (ready stays 1) but discarded.
  - No write is issued for them, and `byte_cnt` saturates.
  - `drop_o` is set.
  - `rx_last_i` on a dropped byte goes to HDR if the macro is defined, otherwise RUN, with no extra write. A partial word is still pending at that point only if `MAX_BYTES` is not a multiple of 4, which is forbidden.
- `pkt_len_o` = `byte_cnt`, i.e. the stored bytes only.
- `exec_done_i` outside RUN is ignored. `rx_valid_i` outside RECV is not accepted because `rx_ready_o`=0.

## Timing
- Reset values:
  - All outputs 0, except `start_addr_o` = `BASE_ADDR`.
  - State = RECV, counters 0, `word_buf` 0.
  - `rx_ready_o` = 1 from the first cycle after reset deasserts.
- Throughput: 4 bytes per 5 cycles, i.e. 4 RECV cycles and 1 WRITE cycle.
- Write latency: the WRITE cycle immediately follows the acceptance cycle of lane 3 or of the last byte.
- The memory path is combinational into the clocked SRAM, so each write commits on the WRITE edge. There is no wait state.
- `start_o` rises the cycle after the final WRITE, or after HDR when the macro is defined.
- `start_o` falls in the cycle after `exec_done_i` is sampled high. The next byte can be accepted in that same cycle.
- Reset mid-packet: the partial word is discarded, no write is issued, and `start_o` drops.

## Configuration
- `LOADER_LEN_HDR_EN` defined:
  - After the last data word, one extra HDR write cycle stores `{16'd0, pkt_len}` at `BASE_ADDR - 4`.
  - `BASE_ADDR` must be ≥ 4.
  - `start_o` is delayed one cycle.
- Undefined: no HDR state and no length word is written. `pkt_len_o` is still valid.

## Structure
- Width macros `ADDR_BUS`/`DATA_BUS`, `TRUE`/`FALSE`, and the state encodings (`LD_RECV`, `LD_WRITE`, `LD_HDR`, `LD_RUN`) go in `def.v`.
- No submodule is required. The byte packer may be split out as `byte_packer` (accumulates lanes, flags full or last) if reuse is wanted.

## Test plan
- 8-byte packet 01..08, last on byte 8 → two writes: addr 64 data 0x04030201, addr 68 data 0x08070605. Then `start_o`=1, `pkt_len_o`=8.
- 5-byte packet AA BB CC DD EE → writes 0xDDCCBBAA at 64 and 0x000000EE at 68.
- `exec_done_i` pulsed 10 cycles after `start_o` → `start_o` low next cycle. A second 4-byte packet is written at 64 again.
- `MAX_BYTES`=8, 12-byte packet → only addr 64/68 written, `drop_o`=1, `pkt_len_o`=8. `drop_o` clears after `exec_done_i`.
- `rst` asserted after 3 bytes → no memory write, `start_o`=0. A next 4-byte packet lands cleanly at 64.
- `LOADER_LEN_HDR_EN` with a 6-byte packet → a third write at addr 60 with data 0x00000006, then `start_o`.
